divider_sign_ctrl: RTL and testbench
====================================

Name: divider_sign_ctrl

Overview:
- Signed front/back-end stage for the team's unsigned restoring divider core.
- Accepts signed two's-complement operands over a valid/ready handshake and converts them to magnitudes.
- Launches the core via its start/ready interface, captures the core's quotient/remainder, restores signs, flags divide-by-zero, overflow and timeout, and presents the result on a held valid/ready output.
- Sits between the ALU operand bus and the divider core; the core is external, connected through the core_* ports.

Parameters:
- W, 5, operand/result width; matches core width.
- TIMEOUT, 32, max cycles spent in LAUNCH+WAIT before aborting; must be at least 2*2^(clog2(W)+1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept operands.
- in_dividend  in  W  signed dividend.
- in_divisor  in  W  signed divisor.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer accepts result.
- out_quotient  out  W  signed quotient, truncated toward zero.
- out_remainder  out  W  signed remainder; sign follows dividend.
- out_dbz  out  1  divide-by-zero flag.
- out_ovf  out  1  overflow flag (most-negative / -1).
- out_tmo  out  1  core timeout flag.
- core_start  out  1  launch request to core.
- core_dividend  out  W  unsigned dividend magnitude.
- core_divisor  out  W  unsigned divisor magnitude.
- core_ready  in  1  core idle/done; may be a single-cycle pulse.
- core_quotient  in  W  unsigned quotient from core.
- core_remainder  in  W  unsigned remainder from core.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All out_* = 0, core_start = 0, core_* operand regs = 0, timeout counter = 0.
  - in_ready = 1 once reset is released.
- States: IDLE, LAUNCH, WAIT, DONE.
  - **IDLE:** in_ready=1. On in_valid, register the operands and compute the flags sa = dividend MSB, sb = divisor MSB.
    - Divisor == 0: go straight to DONE with quotient = all ones, remainder = dividend, dbz=1. The core is never started.
    - Otherwise: core_dividend = |dividend|, core_divisor = |divisor| as W-bit unsigned (magnitude of -2^(W-1) is 2^(W-1), representable unsigned). Go to LAUNCH.
  - **LAUNCH:** core_start=1. The launch is taken on the edge where core_start && core_ready. At that edge, go to WAIT and reset the timeout counter. core_start drops in WAIT.
  - **WAIT:** on the first cycle with core_ready=1, capture the sign-corrected results at that edge and go to DONE.
    - Quotient = sa^sb ? -core_quotient : core_quotient, taken mod 2^W.
    - Remainder = sa ? -core_remainder : core_remainder.
    - ovf=1 iff dividend = -2^(W-1) and divisor = -1. The quotient then wraps to -2^(W-1).
  - **DONE:** out_valid=1; all out_* held stable. On out_ready, clear out_valid and go to IDLE. in_ready=0 in DONE, so there is no back-to-back bypass.
- Timeout:
  - The counter runs while in LAUNCH or WAIT.
  - On reaching TIMEOUT-1, go to DONE with tmo=1, quotient=0, remainder=0, core_start deasserted.
- Latency, for a core with level ready and W iterations, from the in_valid&&in_ready edge to out_valid:
  - Non-zero divisor: W+2 edges (7 for W=5).
  - DBZ: 1 edge.
- in_valid while not in IDLE is ignored. Operands must be held by the producer until in_ready.
- Reset mid-operation aborts immediately.
  - The core may still be busy; the next LAUNCH simply waits for core_ready.
- out_dbz, out_ovf and out_tmo are mutually exclusive.
- All three flags are cleared on the out_ready handshake.

Decomposition:
- Shared package divider_pkg:
  - State enum (IDLE/LAUNCH/WAIT/DONE, 2-bit).
  - W default.
  - TIMEOUT default.
  - Flag bit positions for a packed status word {tmo, ovf, dbz}.
- One natural sub-module: sign_mag, a combinational W-bit two's-complement magnitude/negate helper. It is used for both operand conversion and result correction.

Test Plan:
- 7 / 2 -> core sees 7,2; out_quotient=3, out_remainder=1, flags 0; out_valid 7 cycles after accept.
- -7 / 2 -> core sees 7,2; out_quotient=-3 (5'b11101), out_remainder=-1 (5'b11111).
- 7 / -2 -> out_quotient=-3, out_remainder=1.
- -7 / -2 -> out_quotient=3, out_remainder=-1.
- 9 / 0 -> core_start never asserted; out_dbz=1, out_quotient=5'b11111, out_remainder=9, 1 cycle after accept.
- -16 / -1 -> out_ovf=1, out_quotient=5'b10000.
- Core model whose ready never returns -> out_tmo=1 after 32 cycles.
- Hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0.
- rst_n pulsed low in WAIT -> all outputs 0 immediately, next op (6/3 -> 2 r0) correct.

Source files
------------

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and defaults for the signed divider front/back-end
package divider_pkg;

    localparam int W_DEF       = 5;
    localparam int TIMEOUT_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Bit positions inside the packed status word {tmo, ovf, dbz}
    localparam int FLAG_DBZ = 0;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_TMO = 2;
    localparam int FLAG_W   = 3;

endpackage

// File: rtl/divider_sign_ctrl_sign_mag.sv
// rtl/divider_sign_ctrl_sign_mag.sv - combinational two's-complement conditional negate
module sign_mag #(
    parameter int W = 5
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    // With negate tied to the MSB this yields the magnitude; -2^(W-1) maps onto itself,
    // which read as unsigned is exactly 2^(W-1).
    always_comb begin
        result = value;
        if (negate) begin
            result = ~value + W'(1);
        end
    end

endmodule

// File: rtl/divider_sign_ctrl.sv
// rtl/divider_sign_ctrl.sv - signed wrapper around the unsigned restoring divider core
module divider_sign_ctrl
    import divider_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_dividend,
    input  logic [W-1:0] in_divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_quotient,
    output logic [W-1:0] out_remainder,
    output logic         out_dbz,
    output logic         out_ovf,
    output logic         out_tmo,
    output logic         core_start,
    output logic [W-1:0] core_dividend,
    output logic [W-1:0] core_divisor,
    input  logic         core_ready,
    input  logic [W-1:0] core_quotient,
    input  logic [W-1:0] core_remainder
);

    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [W-1:0]  MOST_NEG  = {1'b1, {(W-1){1'b0}}};

    state_e              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [W-1:0]        quot_q, quot_d;
    logic [W-1:0]        rem_q, rem_d;
    logic [FLAG_W-1:0]   status_q, status_d;
    logic                core_start_q, core_start_d;
    logic [W-1:0]        core_dvd_q, core_dvd_d;
    logic [W-1:0]        core_dvs_q, core_dvs_d;
    logic [CW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic                ovf_pend_q, ovf_pend_d;

    logic [W-1:0]        dvd_mag;
    logic [W-1:0]        dvs_mag;
    logic [W-1:0]        quot_fix;
    logic [W-1:0]        rem_fix;

    sign_mag #(.W(W)) u_dvd_mag (
        .value  (in_dividend),
        .negate (in_dividend[W-1]),
        .result (dvd_mag)
    );

    sign_mag #(.W(W)) u_dvs_mag (
        .value  (in_divisor),
        .negate (in_divisor[W-1]),
        .result (dvs_mag)
    );

    sign_mag #(.W(W)) u_quot_fix (
        .value  (core_quotient),
        .negate (sa_q ^ sb_q),
        .result (quot_fix)
    );

    sign_mag #(.W(W)) u_rem_fix (
        .value  (core_remainder),
        .negate (sa_q),
        .result (rem_fix)
    );

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        quot_d       = quot_q;
        rem_d        = rem_q;
        status_d     = status_q;
        core_start_d = core_start_q;
        core_dvd_d   = core_dvd_q;
        core_dvs_d   = core_dvs_q;
        tmo_cnt_d    = tmo_cnt_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        ovf_pend_d   = ovf_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sa_d       = in_dividend[W-1];
                    sb_d       = in_divisor[W-1];
                    ovf_pend_d = (in_dividend == MOST_NEG) && (in_divisor == '1);
                    if (in_divisor == '0) begin
                        state_d            = ST_DONE;
                        out_valid_d        = 1'b1;
                        quot_d             = '1;
                        rem_d              = in_dividend;
                        status_d           = '0;
                        status_d[FLAG_DBZ] = 1'b1;
                    end else begin
                        state_d      = ST_LAUNCH;
                        core_dvd_d   = dvd_mag;
                        core_dvs_d   = dvs_mag;
                        core_start_d = 1'b1;
                        tmo_cnt_d    = '0;
                    end
                end
            end

            ST_LAUNCH: begin
                if (core_start_q && core_ready) begin
                    state_d      = ST_WAIT;
                    core_start_d = 1'b0;
                    tmo_cnt_d    = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d            = ST_DONE;
                    out_valid_d        = 1'b1;
                    core_start_d       = 1'b0;
                    quot_d             = '0;
                    rem_d              = '0;
                    status_d           = '0;
                    status_d[FLAG_TMO] = 1'b1;
                    tmo_cnt_d          = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CW'(1);
                end
            end

            ST_WAIT: begin
                // A completion on the last allowed cycle still wins over the timeout
                if (core_ready) begin
                    state_d            = ST_DONE;
                    out_valid_d        = 1'b1;
                    quot_d             = quot_fix;
                    rem_d              = rem_fix;
                    status_d           = '0;
                    status_d[FLAG_OVF] = ovf_pend_q;
                    tmo_cnt_d          = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d            = ST_DONE;
                    out_valid_d        = 1'b1;
                    quot_d             = '0;
                    rem_d              = '0;
                    status_d           = '0;
                    status_d[FLAG_TMO] = 1'b1;
                    tmo_cnt_d          = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CW'(1);
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    status_d    = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            quot_q       <= '0;
            rem_q        <= '0;
            status_q     <= '0;
            core_start_q <= 1'b0;
            core_dvd_q   <= '0;
            core_dvs_q   <= '0;
            tmo_cnt_q    <= '0;
            sa_q         <= 1'b0;
            sb_q         <= 1'b0;
            ovf_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            quot_q       <= quot_d;
            rem_q        <= rem_d;
            status_q     <= status_d;
            core_start_q <= core_start_d;
            core_dvd_q   <= core_dvd_d;
            core_dvs_q   <= core_dvs_d;
            tmo_cnt_q    <= tmo_cnt_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            ovf_pend_q   <= ovf_pend_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_quotient  = quot_q;
    assign out_remainder = rem_q;
    assign out_dbz       = status_q[FLAG_DBZ];
    assign out_ovf       = status_q[FLAG_OVF];
    assign out_tmo       = status_q[FLAG_TMO];
    assign core_start    = core_start_q;
    assign core_dividend = core_dvd_q;
    assign core_divisor  = core_dvs_q;

endmodule

// File: tb/tb_divider_sign_ctrl.sv
// tb/tb_divider_sign_ctrl.sv - self-checking bench for divider_sign_ctrl
module tb_divider_sign_ctrl;

    localparam int W = 5;
    localparam int TIMEOUT = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_dividend = '0;
    logic [W-1:0] in_divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_quotient;
    logic [W-1:0] out_remainder;
    logic         out_dbz, out_ovf, out_tmo;
    logic         core_start;
    logic [W-1:0] core_dividend, core_divisor;
    logic         core_ready = 1'b1;
    logic [W-1:0] core_quotient = '0;
    logic [W-1:0] core_remainder = '0;

    int checks = 0;
    int failures = 0;

    divider_sign_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_dbz(out_dbz), .out_ovf(out_ovf), .out_tmo(out_tmo),
        .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
        .core_ready(core_ready), .core_quotient(core_quotient), .core_remainder(core_remainder)
    );

    always #5 clk = ~clk;

    // Behavioural unsigned core: W-iteration latency, level ready, optional hang
    logic         core_hang = 1'b0;
    int           core_cnt = 0;
    int           start_cycles = 0;
    logic [W-1:0] seen_dvd = '0;
    logic [W-1:0] seen_dvs = '0;

    always @(posedge clk) begin
        if (core_start) start_cycles <= start_cycles + 1;
        if (core_start && core_ready) begin
            core_ready     <= 1'b0;
            core_cnt       <= W - 2;
            seen_dvd       <= core_dividend;
            seen_dvs       <= core_divisor;
            core_quotient  <= (core_divisor == '0) ? '1 : core_dividend / core_divisor;
            core_remainder <= (core_divisor == '0) ? core_dividend : core_dividend % core_divisor;
        end else if (!core_ready && !core_hang) begin
            if (core_cnt == 0) core_ready <= 1'b1;
            else core_cnt <= core_cnt - 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] q, output logic [W-1:0] r,
                                      output logic [2:0] f);
        int ai, bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            q = '1; r = a; f = 3'b001;
        end else if (ai == -(1 << (W-1)) && bi == -1) begin
            q = W'(ai * -1); r = '0; f = 3'b010;
        end else begin
            q = W'(ai / bi); r = W'(ai % bi); f = 3'b000;
        end
    endfunction

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        int vi;
        vi = int'($signed(v));
        return W'((vi < 0) ? -vi : vi);
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic [2:0] ef,
                         input int exp_lat, input int hold);
        int n, lat, unstable, starts0;
        logic [2*W+2:0] snap;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) check("in_ready_wait", 0, 1);
        starts0 = start_cycles;
        in_valid = 1'b1; in_dividend = a; in_divisor = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        if (exp_lat > 0) check($sformatf("latency %0d/%0d", $signed(a), $signed(b)), lat, exp_lat);
        check($sformatf("quot %0d/%0d", $signed(a), $signed(b)), int'(out_quotient), int'(eq));
        check($sformatf("rem %0d/%0d", $signed(a), $signed(b)), int'(out_remainder), int'(er));
        check($sformatf("flags %0d/%0d", $signed(a), $signed(b)), int'({out_tmo, out_ovf, out_dbz}), int'(ef));
        if (ef[0]) begin
            check("dbz_no_start", start_cycles - starts0, 0);
        end else begin
            check("core_dividend_seen", int'(seen_dvd), int'(mag(a)));
            check("core_divisor_seen", int'(seen_dvs), int'(mag(b)));
        end
        if (hold > 0) begin
            snap = {out_quotient, out_remainder, out_tmo, out_ovf, out_dbz};
            unstable = 0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (!out_valid || in_ready || core_start ||
                    snap != {out_quotient, out_remainder, out_tmo, out_ovf, out_dbz})
                    unstable++;
            end
            check("hold_stable", unstable, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_cleared", int'(out_valid), 0);
        check("flags_cleared", int'({out_tmo, out_ovf, out_dbz}), 0);
    endtask

    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic [2:0]   f;
        int           lat;
        int           hold;
    } vec_t;

    vec_t vecs[7];
    logic [W-1:0] ra, rb, mq, mr;
    logic [2:0]   mf;

    initial begin
        vecs[0] = '{5'd7,      5'd2,      5'd3,      5'd1,      3'b000, 7, 0};
        vecs[1] = '{5'b11001,  5'd2,      5'b11101,  5'b11111,  3'b000, 7, 0};
        vecs[2] = '{5'd7,      5'b11110,  5'b11101,  5'd1,      3'b000, 7, 0};
        vecs[3] = '{5'b11001,  5'b11110,  5'd3,      5'b11111,  3'b000, 7, 0};
        vecs[4] = '{5'd9,      5'd0,      5'b11111,  5'd9,      3'b001, 1, 0};
        vecs[5] = '{5'b10000,  5'b11111,  5'b10000,  5'd0,      3'b010, 7, 0};
        vecs[6] = '{5'd7,      5'd2,      5'd3,      5'd1,      3'b000, 7, 10};

        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_core_start", int'(core_start), 0);
        check("rst_results", int'({out_quotient, out_remainder, core_dividend, core_divisor}), 0);
        check("rst_flags", int'({out_tmo, out_ovf, out_dbz}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", int'(in_ready), 1);

        foreach (vecs[i])
            do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].f, vecs[i].lat, vecs[i].hold);

        // Core never returns ready after launch: launch edge plus TIMEOUT more edges
        core_hang = 1'b1;
        do_op(5'd5, 5'd1, 5'd0, 5'd0, 3'b100, 2 + TIMEOUT, 0);
        check("tmo_core_start_low", int'(core_start), 0);
        core_hang = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Reset while waiting on the core
        in_valid = 1'b1; in_dividend = 5'd7; in_divisor = 5'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_core_start", int'(core_start), 0);
        check("midrst_regs", int'({out_quotient, out_remainder, core_dividend, core_divisor}), 0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", int'(in_ready), 1);
        repeat (5) @(posedge clk);
        #1;
        do_op(5'd6, 5'd3, 5'd2, 5'd0, 3'b000, 7, 0);

        for (int k = 0; k < 40; k++) begin
            ra = W'($urandom_range(0, 31));
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin rb = '1; ra = (k % 2 == 0) ? 5'b10000 : ra; end
                default: rb = W'($urandom_range(0, 31));
            endcase
            ref_model(ra, rb, mq, mr, mf);
            do_op(ra, rb, mq, mr, mf, mf[0] ? 1 : 7, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
